// File: rtl/vc_input_unit.sv
// vc_input_unit
// Multi-VC router input unit. Each virtual channel owns a circular flit FIFO with a
// route sideband per entry and an IDLE/VC/SWITCH packet FSM. Popped flits leave through
// a single registered output stage tagged with the downstream VC won in VC allocation.
// Per-VC on/off backpressure tells the upstream link when a VC is close to full.
module vc_input_unit #(
  parameter int VC_NUM      = 2,
  parameter int BUFFER_SIZE = 8,
  parameter int FLIT_W      = 32,
  parameter int PORT_W      = 3,
  parameter int OFF_TH      = 6,
  localparam int VC_W       = (VC_NUM > 1) ? $clog2(VC_NUM) : 1,
  localparam int PTR_W      = $clog2(BUFFER_SIZE),
  localparam int CNT_W      = $clog2(BUFFER_SIZE) + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en_i,
  input  logic [VC_W-1:0]          wr_vc_i,
  input  logic [FLIT_W-1:0]        flit_i,
  input  logic [PORT_W-1:0]        route_i,
  output logic [VC_NUM-1:0]        vc_req_o,
  output logic [VC_NUM*PORT_W-1:0] out_port_o,
  input  logic [VC_NUM-1:0]        vc_gnt_i,
  input  logic [VC_NUM*VC_W-1:0]   vc_new_i,
  output logic [VC_NUM-1:0]        sw_req_o,
  input  logic [VC_NUM-1:0]        sw_gnt_i,
  output logic [FLIT_W-1:0]        flit_o,
  output logic [VC_W-1:0]          flit_vc_o,
  output logic                     flit_valid_o,
  output logic [VC_NUM-1:0]        empty_o,
  output logic [VC_NUM-1:0]        full_o,
  output logic [VC_NUM-1:0]        on_off_o,
  output logic                     err_o
);

  // Flit type encoding carried in the two most significant flit bits
  localparam logic [1:0] FT_HEAD     = 2'b00;
  localparam logic [1:0] FT_BODY     = 2'b01;
  localparam logic [1:0] FT_TAIL     = 2'b10;
  localparam logic [1:0] FT_HEADTAIL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_VC     = 2'b01,
    ST_SWITCH = 2'b10
  } vc_state_t;

  // Per-VC packet state and FIFO bookkeeping
  vc_state_t         state_q     [VC_NUM];
  vc_state_t         state_d     [VC_NUM];
  logic [PTR_W-1:0]  rd_ptr_q    [VC_NUM];
  logic [PTR_W-1:0]  wr_ptr_q    [VC_NUM];
  logic [CNT_W-1:0]  count_q     [VC_NUM];
  logic [VC_W-1:0]   dvc_q       [VC_NUM];
  logic [PORT_W-1:0] out_port_q  [VC_NUM];

  // Storage: flit payload plus the route that arrived with it
  logic [FLIT_W-1:0] flit_mem    [VC_NUM][BUFFER_SIZE];
  logic [PORT_W-1:0] route_mem   [VC_NUM][BUFFER_SIZE];

  // Combinational views of each FIFO head
  logic [FLIT_W-1:0] front_flit  [VC_NUM];
  logic [PORT_W-1:0] front_route [VC_NUM];

  // Per-cycle control decisions
  logic [VC_NUM-1:0] push;
  logic [VC_NUM-1:0] pop;
  logic [VC_NUM-1:0] sw_pop;
  logic [VC_NUM-1:0] discard_pop;
  logic [VC_NUM-1:0] latch_route;
  logic [VC_NUM-1:0] latch_dvc;
  logic              sw_gnt_legal;
  logic              err_set;

  // Selected flit heading for the output register
  logic              pop_valid;
  logic [FLIT_W-1:0] pop_flit;
  logic [VC_W-1:0]   pop_dvc;

  // FIFO status flags, allocator requests and head-of-queue views, all derived from registered state
  always_comb begin
    vc_req_o   = '0;
    sw_req_o   = '0;
    empty_o    = '0;
    full_o     = '0;
    on_off_o   = '0;
    out_port_o = '0;
    for (int v = 0; v < VC_NUM; v++) begin
      front_flit[v]  = flit_mem[v][rd_ptr_q[v]];
      front_route[v] = route_mem[v][rd_ptr_q[v]];
      empty_o[v]     = (count_q[v] == '0);
      full_o[v]      = (int'(count_q[v]) == BUFFER_SIZE);
      on_off_o[v]    = (int'(count_q[v]) < OFF_TH);
      vc_req_o[v]    = (state_q[v] == ST_VC);
      sw_req_o[v]    = (state_q[v] == ST_SWITCH) && (count_q[v] != '0);
      out_port_o[v*PORT_W +: PORT_W] = out_port_q[v];
    end
  end

  // Next-state logic for every VC FSM plus push/pop arbitration and error detection
  always_comb begin
    logic [1:0] ftype;
    ftype        = FT_HEAD;
    sw_gnt_legal = ((sw_gnt_i & (sw_gnt_i - VC_NUM'(1))) == '0);
    sw_pop       = '0;
    discard_pop  = '0;
    latch_route  = '0;
    latch_dvc    = '0;
    push         = '0;
    pop          = '0;
    pop_valid    = 1'b0;
    pop_flit     = '0;
    pop_dvc      = '0;
    err_set      = !sw_gnt_legal;
    for (int v = 0; v < VC_NUM; v++) begin
      state_d[v] = state_q[v];
      ftype      = front_flit[v][FLIT_W-1 -: 2];
      case (state_q[v])
        ST_IDLE: begin
          if (count_q[v] != '0) begin
            if (ftype == FT_HEAD || ftype == FT_HEADTAIL) begin
              state_d[v]     = ST_VC;
              latch_route[v] = 1'b1;
            end else begin
              discard_pop[v] = 1'b1;
              err_set        = 1'b1;
            end
          end
        end
        ST_VC: begin
          if (vc_gnt_i[v]) begin
            state_d[v]   = ST_SWITCH;
            latch_dvc[v] = 1'b1;
          end
        end
        ST_SWITCH: begin
          if (sw_gnt_legal && sw_gnt_i[v] && sw_req_o[v]) begin
            sw_pop[v] = 1'b1;
            if (ftype == FT_TAIL || ftype == FT_HEADTAIL) begin
              state_d[v] = ST_IDLE;
            end
          end
        end
        default: begin
          state_d[v] = ST_IDLE;
        end
      endcase
      if (sw_gnt_legal && sw_gnt_i[v] && !sw_req_o[v]) begin
        err_set = 1'b1;
      end
      pop[v] = sw_pop[v] | discard_pop[v];
      if (sw_pop[v]) begin
        pop_valid = 1'b1;
        pop_flit  = front_flit[v];
        pop_dvc   = dvc_q[v];
      end
      if (wr_en_i && (int'(wr_vc_i) == v)) begin
        if (!full_o[v] || pop[v]) begin
          push[v] = 1'b1;
        end else begin
          err_set = 1'b1;
        end
      end
    end
    if (wr_en_i && (int'(wr_vc_i) >= VC_NUM)) begin
      err_set = 1'b1;
    end
  end

  // FIFO pointers and occupancy; power-of-two depth lets the pointers wrap naturally
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int v = 0; v < VC_NUM; v++) begin
        rd_ptr_q[v] <= '0;
        wr_ptr_q[v] <= '0;
        count_q[v]  <= '0;
      end
    end else begin
      for (int v = 0; v < VC_NUM; v++) begin
        if (push[v]) begin
          wr_ptr_q[v] <= wr_ptr_q[v] + PTR_W'(1);
        end
        if (pop[v]) begin
          rd_ptr_q[v] <= rd_ptr_q[v] + PTR_W'(1);
        end
        count_q[v] <= count_q[v] + CNT_W'(push[v]) - CNT_W'(pop[v]);
      end
    end
  end

  // Flit and route storage; contents are meaningless once the pointers are reset
  always_ff @(posedge clk) begin
    for (int v = 0; v < VC_NUM; v++) begin
      if (push[v]) begin
        flit_mem[v][wr_ptr_q[v]]  <= flit_i;
        route_mem[v][wr_ptr_q[v]] <= route_i;
      end
    end
  end

  // Packet FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int v = 0; v < VC_NUM; v++) begin
        state_q[v] <= ST_IDLE;
      end
    end else begin
      for (int v = 0; v < VC_NUM; v++) begin
        state_q[v] <= state_d[v];
      end
    end
  end

  // Per-packet context: output port from the head's sideband, downstream VC from the grant
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int v = 0; v < VC_NUM; v++) begin
        out_port_q[v] <= '0;
        dvc_q[v]      <= '0;
      end
    end else begin
      for (int v = 0; v < VC_NUM; v++) begin
        if (latch_route[v]) begin
          out_port_q[v] <= front_route[v];
        end
        if (latch_dvc[v]) begin
          dvc_q[v] <= vc_new_i[v*VC_W +: VC_W];
        end
      end
    end
  end

  // Registered output stage; the flit holds its last value while valid is low
  always_ff @(posedge clk) begin
    if (rst) begin
      flit_o       <= '0;
      flit_vc_o    <= '0;
      flit_valid_o <= 1'b0;
    end else begin
      flit_valid_o <= pop_valid;
      if (pop_valid) begin
        flit_o    <= pop_flit;
        flit_vc_o <= pop_dvc;
      end
    end
  end

  // Sticky protocol error flag, only reset clears it
  always_ff @(posedge clk) begin
    if (rst) begin
      err_o <= 1'b0;
    end else if (err_set) begin
      err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vc_input_unit.sv
// tb_vc_input_unit
// Directed test of vc_input_unit. Stimulus tasks push the expected output flits into
// a scoreboard queue; an independent monitor pops and compares on every flit_valid_o.
module tb_vc_input_unit;

  localparam int VC_NUM      = 2;
  localparam int BUFFER_SIZE = 8;
  localparam int FLIT_W      = 32;
  localparam int PORT_W      = 3;
  localparam int OFF_TH      = 6;
  localparam int VC_W        = 1;

  localparam logic [1:0] FT_HEAD = 2'b00;
  localparam logic [1:0] FT_BODY = 2'b01;
  localparam logic [1:0] FT_TAIL = 2'b10;
  localparam logic [1:0] FT_HT   = 2'b11;

  typedef struct packed {
    logic [FLIT_W-1:0] flit;
    logic [VC_W-1:0]   vc;
  } exp_t;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     wr_en_i = 1'b0;
  logic [VC_W-1:0]          wr_vc_i = '0;
  logic [FLIT_W-1:0]        flit_i = '0;
  logic [PORT_W-1:0]        route_i = '0;
  logic [VC_NUM-1:0]        vc_req_o;
  logic [VC_NUM*PORT_W-1:0] out_port_o;
  logic [VC_NUM-1:0]        vc_gnt_i = '0;
  logic [VC_NUM*VC_W-1:0]   vc_new_i = '0;
  logic [VC_NUM-1:0]        sw_req_o;
  logic [VC_NUM-1:0]        sw_gnt_i = '0;
  logic [FLIT_W-1:0]        flit_o;
  logic [VC_W-1:0]          flit_vc_o;
  logic                     flit_valid_o;
  logic [VC_NUM-1:0]        empty_o;
  logic [VC_NUM-1:0]        full_o;
  logic [VC_NUM-1:0]        on_off_o;
  logic                     err_o;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  vc_input_unit #(
    .VC_NUM(VC_NUM), .BUFFER_SIZE(BUFFER_SIZE), .FLIT_W(FLIT_W),
    .PORT_W(PORT_W), .OFF_TH(OFF_TH)
  ) dut (
    .clk(clk), .rst(rst), .wr_en_i(wr_en_i), .wr_vc_i(wr_vc_i), .flit_i(flit_i),
    .route_i(route_i), .vc_req_o(vc_req_o), .out_port_o(out_port_o),
    .vc_gnt_i(vc_gnt_i), .vc_new_i(vc_new_i), .sw_req_o(sw_req_o), .sw_gnt_i(sw_gnt_i),
    .flit_o(flit_o), .flit_vc_o(flit_vc_o), .flit_valid_o(flit_valid_o),
    .empty_o(empty_o), .full_o(full_o), .on_off_o(on_off_o), .err_o(err_o)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Safety net so a stuck run still ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Monitor: every valid output flit must match the oldest scoreboard entry
  always @(negedge clk) begin
    exp_t e;
    if (flit_valid_o === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("[TB] FAIL unexpected_flit: got flit=%h vc=%0d, required no output", flit_o, flit_vc_o);
      end else begin
        e = exp_q.pop_front();
        if (flit_o !== e.flit || flit_vc_o !== e.vc) begin
          bad++;
          $display("[TB] FAIL out_flit: got flit=%h vc=%0d, required flit=%h vc=%0d",
                   flit_o, flit_vc_o, e.flit, e.vc);
        end
      end
    end
  end

  function automatic logic [FLIT_W-1:0] mk(input logic [1:0] t, input int p);
    return {t, p[FLIT_W-3:0]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One cycle of stimulus, then all request inputs return to idle
  task automatic applyStimulus(input logic wr, input logic [VC_W-1:0] wvc,
                               input logic [FLIT_W-1:0] f, input logic [PORT_W-1:0] rt,
                               input logic [VC_NUM-1:0] vgnt, input logic [VC_NUM*VC_W-1:0] vnew,
                               input logic [VC_NUM-1:0] sgnt);
    wr_en_i  = wr;
    wr_vc_i  = wvc;
    flit_i   = f;
    route_i  = rt;
    vc_gnt_i = vgnt;
    vc_new_i = vnew;
    sw_gnt_i = sgnt;
    step();
    wr_en_i  = 1'b0;
    vc_gnt_i = '0;
    sw_gnt_i = '0;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic writeFlit(input int v, input logic [FLIT_W-1:0] f, input int rt);
    applyStimulus(1'b1, VC_W'(v), f, PORT_W'(rt), '0, '0, '0);
  endtask

  task automatic grantVc(input int v, input int dvc);
    logic [VC_NUM-1:0]      g;
    logic [VC_NUM*VC_W-1:0] n;
    g = '0;
    g[v] = 1'b1;
    n = '0;
    n[v*VC_W +: VC_W] = VC_W'(dvc);
    applyStimulus(1'b0, '0, '0, '0, g, n, '0);
  endtask

  task automatic popFlit(input int v, input logic [FLIT_W-1:0] f, input int dvc);
    logic [VC_NUM-1:0] g;
    exp_t e;
    g = '0;
    g[v] = 1'b1;
    e.flit = f;
    e.vc   = VC_W'(dvc);
    exp_q.push_back(e);
    applyStimulus(1'b0, '0, '0, '0, '0, '0, g);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_vc_req"},     32'(vc_req_o),     32'h0);
    checkOutput({tag, "_sw_req"},     32'(sw_req_o),     32'h0);
    checkOutput({tag, "_out_port"},   32'(out_port_o),   32'h0);
    checkOutput({tag, "_flit"},       32'(flit_o),       32'h0);
    checkOutput({tag, "_flit_vc"},    32'(flit_vc_o),    32'h0);
    checkOutput({tag, "_flit_valid"}, 32'(flit_valid_o), 32'h0);
    checkOutput({tag, "_empty"},      32'(empty_o),      32'h3);
    checkOutput({tag, "_full"},       32'(full_o),       32'h0);
    checkOutput({tag, "_on_off"},     32'(on_off_o),     32'h3);
    checkOutput({tag, "_err"},        32'(err_o),        32'h0);
  endtask

  initial begin
    // Reset values
    repeat (2) @(posedge clk);
    #1;
    checkResetState("reset");
    rst = 1'b0;

    // Three-flit packet on VC0, route taken from the head's sideband
    writeFlit(0, mk(FT_HEAD, 'h11), 2);
    writeFlit(0, mk(FT_BODY, 'h12), 7);
    writeFlit(0, mk(FT_TAIL, 'h13), 5);
    checkOutput("t1_vc_req", 32'(vc_req_o), 32'h1);
    checkOutput("t1_sw_req_before_gnt", 32'(sw_req_o), 32'h0);
    checkOutput("t1_out_port", 32'(out_port_o), 32'h2);
    grantVc(0, 1);
    checkOutput("t1_sw_req", 32'(sw_req_o), 32'h1);
    checkOutput("t1_vc_req_after_gnt", 32'(vc_req_o), 32'h0);
    popFlit(0, mk(FT_HEAD, 'h11), 1);
    popFlit(0, mk(FT_BODY, 'h12), 1);
    popFlit(0, mk(FT_TAIL, 'h13), 1);
    checkOutput("t1_empty", 32'(empty_o), 32'h3);
    checkOutput("t1_idle_sw_req", 32'(sw_req_o), 32'h0);
    checkOutput("t1_idle_vc_req", 32'(vc_req_o), 32'h0);
    checkOutput("t1_err", 32'(err_o), 32'h0);

    // Fill VC1, then overflow with and without a same-cycle pop
    for (int i = 0; i < BUFFER_SIZE; i++) begin
      writeFlit(1, (i == 0) ? mk(FT_HEAD, 'h20) : mk(FT_BODY, 'h20 + i), 4);
      checkOutput($sformatf("t2_on_off_%0d", i + 1), 32'(on_off_o[1]), (i + 1 < OFF_TH) ? 32'h1 : 32'h0);
      checkOutput($sformatf("t2_full_%0d", i + 1), 32'(full_o[1]), (i + 1 == BUFFER_SIZE) ? 32'h1 : 32'h0);
    end
    grantVc(1, 0);
    begin
      exp_t e;
      e.flit = mk(FT_HEAD, 'h20);
      e.vc   = 1'b0;
      exp_q.push_back(e);
    end
    applyStimulus(1'b1, 1'b1, mk(FT_TAIL, 'h28), 3'd0, '0, '0, 2'b10);
    checkOutput("t2_full_after_push_pop", 32'(full_o), 32'h2);
    checkOutput("t2_err_push_pop", 32'(err_o), 32'h0);
    writeFlit(1, mk(FT_BODY, 'h29), 0);
    checkOutput("t2_err_overflow", 32'(err_o), 32'h1);
    checkOutput("t2_full_after_drop", 32'(full_o), 32'h2);
    for (int k = 1; k < BUFFER_SIZE; k++) begin
      popFlit(1, mk(FT_BODY, 'h20 + k), 0);
    end
    popFlit(1, mk(FT_TAIL, 'h28), 0);
    checkOutput("t2_empty", 32'(empty_o), 32'h3);
    checkOutput("t2_sw_req", 32'(sw_req_o), 32'h0);
    rst = 1'b1;
    step();
    checkResetState("reset2");
    rst = 1'b0;

    // Interleaved packets: each VC carries its own route and downstream VC
    writeFlit(0, mk(FT_HEAD, 'h30), 3);
    writeFlit(1, mk(FT_HEAD, 'h40), 4);
    writeFlit(0, mk(FT_TAIL, 'h31), 0);
    writeFlit(1, mk(FT_TAIL, 'h41), 0);
    checkOutput("t3_vc_req", 32'(vc_req_o), 32'h3);
    checkOutput("t3_out_port", 32'(out_port_o), 32'h23);
    grantVc(1, 0);
    checkOutput("t3_vc_req_vc0_waiting", 32'(vc_req_o), 32'h1);
    checkOutput("t3_sw_req_vc1", 32'(sw_req_o), 32'h2);
    popFlit(1, mk(FT_HEAD, 'h40), 0);
    popFlit(1, mk(FT_TAIL, 'h41), 0);
    checkOutput("t3_vc0_unaffected", 32'(vc_req_o), 32'h1);
    grantVc(0, 1);
    popFlit(0, mk(FT_HEAD, 'h30), 1);
    popFlit(0, mk(FT_TAIL, 'h31), 1);
    checkOutput("t3_empty", 32'(empty_o), 32'h3);
    checkOutput("t3_err", 32'(err_o), 32'h0);

    // HEADTAIL single-flit packets, enough of them to wrap the VC1 pointers twice
    writeFlit(0, mk(FT_HT, 'h50), 1);
    step();
    grantVc(0, 0);
    checkOutput("t6_sw_req", 32'(sw_req_o), 32'h1);
    popFlit(0, mk(FT_HT, 'h50), 0);
    checkOutput("t6_ht_vc_req", 32'(vc_req_o), 32'h0);
    checkOutput("t6_ht_sw_req", 32'(sw_req_o), 32'h0);
    checkOutput("t6_ht_empty", 32'(empty_o), 32'h3);
    for (int i = 0; i < 2 * BUFFER_SIZE; i++) begin
      writeFlit(1, mk(FT_HT, 'h60 + i), i % 5);
      step();
      checkOutput($sformatf("t6_wrap_route_%0d", i), 32'(out_port_o[2*PORT_W-1:PORT_W]), 32'(i % 5));
      grantVc(1, i % 2);
      popFlit(1, mk(FT_HT, 'h60 + i), i % 2);
    end
    checkOutput("t6_wrap_empty", 32'(empty_o), 32'h3);
    checkOutput("t6_err", 32'(err_o), 32'h0);

    // Illegal multi-hot switch grant, then reset in the middle of a packet
    writeFlit(0, mk(FT_HEAD, 'h70), 2);
    writeFlit(0, mk(FT_BODY, 'h71), 0);
    grantVc(0, 1);
    checkOutput("t5_sw_req", 32'(sw_req_o), 32'h1);
    applyStimulus(1'b0, '0, '0, '0, '0, '0, 2'b11);
    checkOutput("t5_err", 32'(err_o), 32'h1);
    checkOutput("t5_no_pop_valid", 32'(flit_valid_o), 32'h0);
    checkOutput("t5_no_pop_sw_req", 32'(sw_req_o), 32'h1);
    checkOutput("t5_no_pop_empty", 32'(empty_o), 32'h2);
    rst = 1'b1;
    step();
    checkResetState("reset3");
    rst = 1'b0;

    // Stray BODY flit into an idle VC is discarded and flagged
    writeFlit(0, mk(FT_BODY, 'h80), 0);
    checkOutput("t4_err_before", 32'(err_o), 32'h0);
    step();
    checkOutput("t4_err", 32'(err_o), 32'h1);
    checkOutput("t4_empty", 32'(empty_o), 32'h3);
    checkOutput("t4_vc_req", 32'(vc_req_o), 32'h0);
    step();
    checkOutput("t4_vc_req_later", 32'(vc_req_o), 32'h0);

    step();
    step();
    checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
